// File: rtl/eth_uart_hex_dumper.sv
// Ethernet FIFO hex dumper: renders frame bytes as ASCII hex on a UART.
// Define ETH_UART_DUMP_PARITY_EN for 8E1 framing instead of 8N1.
module eth_uart_hex_dumper #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [9:0] fifo_rd_data,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       dump_active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef ETH_UART_DUMP_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, EMIT, WAIT_TX
  } state_t;

  state_t          state, next;
  logic            rd_req;
  logic            tx_start;
  logic            tx_done;
  logic [7:0]      tx_data;
  logic [FW-1:0]   frame;
  logic [FW-1:0]   shreg;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [4:0][7:0] list_q;
  logic [4:0][7:0] nl;
  logic [2:0]      cnt_q;
  logic [2:0]      idx_q;
  logic [2:0]      ncnt;
  logic [2:0]      k;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n}
                       : 8'h37 + {4'h0, n};
  endfunction

  // Read strobe is forced low while reset is held.
  assign fifo_rd_en = rd_req & rst_n;
  assign tx_data    = list_q[idx_q];
  assign uart_tx    = ~tx_busy | shreg[0];
  assign tx_done    = tx_busy
                   && baud_cnt == CW'(CLKS_PER_BIT - 1)
                   && bit_cnt == 4'(FW - 1);

`ifdef ETH_UART_DUMP_PARITY_EN
  assign frame = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign frame = {1'b1, tx_data, 1'b0};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Next-state logic, read request and serialiser start.
  always_comb begin
    next     = state;
    rd_req   = 1'b0;
    tx_start = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_req = 1'b1;
          next   = FETCH;
        end
      end
      FETCH: next = LATCH;
      LATCH: next = EMIT;
      EMIT: begin
        tx_start = 1'b1;
        next     = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done)
          next = (idx_q == cnt_q) ? IDLE : EMIT;
      end
      default: next = IDLE;
    endcase
  end

  // Character list for the word on the FIFO read port.
  always_comb begin
    nl   = '0;
    k    = 3'd0;
    ncnt = 3'd0;
    if (fifo_rd_data[9]) begin
      nl[0] = 8'h3C;
      nl[1] = hex(fifo_rd_data[7:4]);
      nl[2] = hex(fifo_rd_data[3:0]);
      k     = 3'd3;
    end else begin
      nl[0] = hex(fifo_rd_data[7:4]);
      nl[1] = hex(fifo_rd_data[3:0]);
      k     = 3'd2;
    end
    if (fifo_rd_data[8]) begin
      nl[k]        = 8'h0D;
      nl[k + 3'd1] = 8'h0A;
      ncnt         = k + 3'd2;
    end else begin
      nl[k] = 8'h20;
      ncnt  = k + 3'd1;
    end
  end

  // Word latch, character index and dump_active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q      <= '0;
      cnt_q       <= 3'd0;
      idx_q       <= 3'd0;
      dump_active <= 1'b0;
    end else begin
      if (state == LATCH) begin
        list_q      <= nl;
        cnt_q       <= ncnt;
        idx_q       <= 3'd0;
        dump_active <= 1'b1;
      end
      if (state == EMIT)
        idx_q <= idx_q + 3'd1;
      if (state == WAIT_TX && tx_done
          && idx_q == cnt_q)
        dump_active <= 1'b0;
    end
  end

  // UART serialiser, LSB first, bit timed by baud_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      shreg    <= frame;
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
    end else if (tx_busy) begin
      if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[FW-1:1]};
        if (bit_cnt == 4'(FW - 1))
          tx_busy <= 1'b0;
        else
          bit_cnt <= bit_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/eth_uart_hex_dumper.md
Name: eth_uart_hex_dumper

Overview:
- Consumes 10-bit words {frame_start, frame_end, byte} from the read side of the Ethernet dual-clock FIFO, in the 50 MHz debug domain.
- Renders each byte as two uppercase ASCII hex characters with delimiters.
- Serialises the characters as 8N1 UART on uart_tx, so captured Ethernet frames can be watched on a terminal.
- Replaces the ad-hoc edge-detect/read-enable glue: the block owns the FIFO read handshake itself.

Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, 434), clocks per UART bit.

Ports:
- clk  in  1  debug clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe, one cycle per word.
- fifo_rd_data  in  10  FIFO word, valid the cycle after fifo_rd_en. Bit 9 = frame_start, bit 8 = frame_end, bits 7:0 = byte.
- uart_tx  out  1  UART serial line, idle high.
- tx_busy  out  1  high while a character is on the line.
- dump_active  out  1  high from fetching a word until its last character's stop bit ends.

Behaviour:
- Reset (async, immediate): fifo_rd_en=0, uart_tx=1, tx_busy=0, dump_active=0. FSM goes to IDLE; all counters clear. A character in flight is abandoned, and the line returns high at once.
- FSM states: IDLE, FETCH, LATCH, EMIT, WAIT_TX.
- IDLE: if fifo_empty=0, pulse fifo_rd_en for exactly one cycle and go to FETCH. Otherwise stay in IDLE.
- FETCH: one-cycle wait for FIFO read latency.
- LATCH: register fifo_rd_data and build the character list:
  - if frame_start: '<' (0x3C);
  - then hi nibble and lo nibble, each mapped 0-9 to 0x30-0x39 and A-F to 0x41-0x46;
  - then, if frame_end: CR (0x0D) and LF (0x0A); otherwise space (0x20).
  - List length is 3 to 5 characters (start+end on one byte gives 5).
  - Set dump_active=1 and go to EMIT.
- EMIT: load the next character into the serialiser and go to WAIT_TX.
- WAIT_TX: when the serialiser reports done:
  - more characters remaining: go to EMIT;
  - list exhausted: clear dump_active and go to IDLE.
- Only one FIFO word is in flight at a time. fifo_rd_en is never asserted outside IDLE or while fifo_empty=1.
- Serialiser, 8N1, LSB first:
  - Frame is start bit 0, data[0..7], stop bit 1; each bit lasts exactly CLKS_PER_BIT clocks, timed by a 0..CLKS_PER_BIT-1 counter.
  - tx_busy rises with the first start-bit cycle and falls after the last stop-bit cycle.
  - Character period = 10*CLKS_PER_BIT clocks (4340 at defaults).
  - Gap between consecutive characters of one word: exactly 1 idle-high clock (EMIT cycle).
- FIFO becoming empty mid-word: no effect; the current word completes.
- fifo_empty deasserting while busy: the word waits in the FIFO; nothing is dropped.

Optional Feature:
- Macro: ETH_UART_DUMP_PARITY_EN.
- Defined: 8E1. An even-parity bit (XOR of data[7:0]) is inserted between data[7] and the stop bit. Character period = 11*CLKS_PER_BIT.
- Undefined: 8N1 as above, with no parity logic.

Test Plan:
- Reset: hold rst_n=0 mid-character -> uart_tx=1, tx_busy=0, fifo_rd_en=0 within the same cycle; nothing is emitted after release while fifo_empty=1.
- Single word 0x25A (start=1, end=0, byte 0x5A) -> one fifo_rd_en pulse; line decodes 0x3C, 0x35, 0x41, 0x20; each character is 4340 clocks with a 1-clock gap.
- Word 0x10F (end=1, byte 0x0F) -> 0x30, 0x46, 0x0D, 0x0A; dump_active falls the cycle after the last stop bit.
- Word 0x3FF (start and end, byte 0xFF) -> 0x3C, 0x46, 0x46, 0x0D, 0x0A (5 characters).
- Back-to-back: FIFO holds 64 bytes 0x00..0x3F, first flagged start and last flagged end -> exactly 64 read pulses, never while empty; the decoded text matches the byte sequence exactly.
- With ETH_UART_DUMP_PARITY_EN: byte 0x07 -> on the '7' character (0x37, five ones) the parity bit is 1; character length is 4774 clocks.
